// File: rtl/conv_layer_stream.sv
// conv_layer_stream
// Streaming valid-mode 2-D convolution. Raster-order pixels are written into a
// KSIZE-row circular line buffer; every time a pixel completes a KSIZE x KSIZE
// window, the block stops accepting input and walks the window one kernel row
// per cycle, KSIZE MACs per output channel. Once the window is done it scales,
// adds the bias and saturates. The result is then held under valid/ready until
// it is accepted. Weights and biases are written at run time, only while idle.
//
// Optional build macro: CONV_RELU_EN -- clamp negative channel results to 0.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_data/in_valid/in_ready    pixel stream (raster order)
//   w_we/w_addr/w_data   weight write: ch*K*K + r*K + c, bias at CH_OUT*K*K + ch
//   out_data/out_valid/out_ready result stream, channel ch at [ch*OUT_W +: OUT_W]
//   busy                 frame in progress
//   frame_done           one-cycle pulse after the last result of a frame is taken
module conv_layer_stream #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KSIZE  = 5,
  parameter int CH_OUT = 3,
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 8,
  localparam int ADDR_W = $clog2(CH_OUT*KSIZE*KSIZE + CH_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     w_we,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic signed [WGT_W-1:0]  w_data,
  output logic [CH_OUT*OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int SLOT_W = $clog2(KSIZE);
  localparam int PROD_W = DATA_W + WGT_W + 1;
  localparam int ACC_W  = DATA_W + WGT_W + $clog2(KSIZE*KSIZE) + 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  COL_K1    = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_K1    = ROW_W'(KSIZE - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(KSIZE - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_COMPUTE, S_OUTPUT} state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0]       r_lbuf [KSIZE][IMG_W];
  logic signed [WGT_W-1:0] r_wgt  [CH_OUT][KSIZE][KSIZE];
  logic signed [WGT_W-1:0] r_bias [CH_OUT];
  logic signed [ACC_W-1:0] r_acc  [CH_OUT];

  logic [COL_W-1:0]  r_col, r_left;
  logic [ROW_W-1:0]  r_row;
  logic [SLOT_W-1:0] r_slot, r_rd_slot, r_k;
  logic              r_fin, r_last, r_busy, r_frame_done, r_alive;
  logic [CH_OUT*OUT_W-1:0] r_out_data;

  logic                    w_in_hs, w_out_hs, w_win_done, w_frame_end;
  logic [DATA_W-1:0]       w_pix     [KSIZE];
  logic signed [ACC_W-1:0] w_row_sum [CH_OUT];
  logic [CH_OUT*OUT_W-1:0] w_result;

  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_win_done  = (r_row >= ROW_K1) && (r_col >= COL_K1);
  assign w_frame_end = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = r_alive;
        if (in_valid && r_alive) w_next = S_STREAM;
      end
      S_STREAM: begin
        in_ready = r_alive;
        if (in_valid && r_alive && w_win_done) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_fin) w_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = r_last ? S_IDLE : S_STREAM;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Window row being processed this cycle, read from the circular row slot.
  always_comb begin
    for (int c = 0; c < KSIZE; c++) begin
      w_pix[c] = r_lbuf[r_rd_slot][r_left + COL_W'(c)];
    end
  end

  always_comb begin
    logic signed [PROD_W-1:0] v_prod;
    v_prod = '0;
    for (int ch = 0; ch < CH_OUT; ch++) begin
      w_row_sum[ch] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        v_prod = PROD_W'($signed({1'b0, w_pix[c]})) * PROD_W'(r_wgt[ch][r_k][c]);
        w_row_sum[ch] = w_row_sum[ch] + ACC_W'(v_prod);
      end
    end
  end

  // Scale, bias, saturate (and optionally rectify) each channel.
  always_comb begin
    logic signed [ACC_W-1:0] v_shift;
    logic signed [ACC_W:0]   v_sum;
    logic signed [OUT_W-1:0] v_sat;
    w_result = '0;
    v_shift  = '0;
    v_sum    = '0;
    v_sat    = '0;
    for (int ch = 0; ch < CH_OUT; ch++) begin
      v_shift = r_acc[ch] >>> SHIFT;
      v_sum   = (ACC_W+1)'(v_shift) + (ACC_W+1)'(r_bias[ch]);
      if (v_sum > SAT_MAX)      v_sat = OUT_W'(SAT_MAX);
      else if (v_sum < SAT_MIN) v_sat = OUT_W'(SAT_MIN);
      else                      v_sat = v_sum[OUT_W-1:0];
`ifdef CONV_RELU_EN
      if (v_sat[OUT_W-1]) v_sat = '0;
`else
`endif
      w_result[ch*OUT_W +: OUT_W] = v_sat;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_slot       <= '0;
      r_left       <= '0;
      r_rd_slot    <= '0;
      r_k          <= '0;
      r_fin        <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_alive      <= 1'b0;
      r_out_data   <= '0;
      for (int ch = 0; ch < CH_OUT; ch++) r_acc[ch] <= '0;
    end else begin
      // in_ready stays low while reset is asserted and for the first edge after it.
      r_alive      <= 1'b1;
      r_state      <= w_next;
      r_frame_done <= 1'b0;
      if (w_in_hs) begin
        r_busy <= 1'b1;
        if (w_win_done) begin
          // Top row of the window is (row+1) mod K, i.e. the slot after this one.
          r_left    <= r_col - COL_K1;
          r_rd_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
          r_last    <= w_frame_end;
          r_k       <= '0;
          r_fin     <= 1'b0;
        end
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row == ROW_LAST) begin
            r_row  <= '0;
            r_slot <= '0;
          end else begin
            r_row  <= r_row + ROW_W'(1);
            r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      // KSIZE accumulate cycles, then one cycle registering the final result.
      if (r_state == S_COMPUTE) begin
        if (!r_fin) begin
          for (int ch = 0; ch < CH_OUT; ch++) begin
            r_acc[ch] <= (r_k == '0) ? w_row_sum[ch] : r_acc[ch] + w_row_sum[ch];
          end
          r_rd_slot <= (r_rd_slot == SLOT_LAST) ? '0 : r_rd_slot + SLOT_W'(1);
          if (r_k == SLOT_LAST) r_fin <= 1'b1;
          else                  r_k   <= r_k + SLOT_W'(1);
        end else begin
          r_out_data <= w_result;
          r_fin      <= 1'b0;
        end
      end
      if (w_out_hs && r_last) begin
        r_busy       <= 1'b0;
        r_frame_done <= 1'b1;
      end
    end
  end

  // NOTE: the line buffer has no reset; every slot is rewritten before a
  // window reads it, so clearing it would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_lbuf[r_slot][r_col] <= in_data;
  end

  // Weights and biases survive reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (w_we && r_state == S_IDLE) begin
      for (int ch = 0; ch < CH_OUT; ch++) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE; c++) begin
            if (w_addr == ADDR_W'(ch*KSIZE*KSIZE + r*KSIZE + c)) r_wgt[ch][r][c] <= w_data;
          end
        end
        if (w_addr == ADDR_W'(CH_OUT*KSIZE*KSIZE + ch)) r_bias[ch] <= w_data;
      end
    end
  end

  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Self-checking bench for conv_layer_stream: a default-parameter instance
// (28x28, K=5) and a small instance (8x6, K=3) share one driver and monitor.
// Expected results come from a direct convolution model and are queued when
// the window-completing pixel is accepted.
module tb_conv_layer_stream;

  localparam int CH = 3;
  localparam int OW = 12;
  localparam int SH = 8;
  localparam int DW = CH*OW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] in_data;
  logic       in_valid, w_we, out_ready, sel;
  logic [6:0] w_addr;
  logic [7:0] w_data;

  logic a_in_ready, a_out_valid, a_busy, a_frame_done;
  logic b_in_ready, b_out_valid, b_busy, b_frame_done;
  logic [DW-1:0] a_out_data, b_out_data;

  conv_layer_stream #(.IMG_W(28), .IMG_H(28), .KSIZE(5), .CH_OUT(CH), .DATA_W(8),
                      .WGT_W(8), .OUT_W(OW), .SHIFT(SH)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(a_in_ready), .w_we(w_we && !sel), .w_addr(w_addr), .w_data(w_data),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .busy(a_busy), .frame_done(a_frame_done));

  conv_layer_stream #(.IMG_W(8), .IMG_H(6), .KSIZE(3), .CH_OUT(CH), .DATA_W(8),
                      .WGT_W(8), .OUT_W(OW), .SHIFT(SH)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(b_in_ready), .w_we(w_we && sel), .w_addr(w_addr[4:0]), .w_data(w_data),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .busy(b_busy), .frame_done(b_frame_done));

  logic          in_ready_m, out_valid_m, busy_m, frame_done_m;
  logic [DW-1:0] out_data_m;
  assign in_ready_m   = sel ? b_in_ready   : a_in_ready;
  assign out_valid_m  = sel ? b_out_valid  : a_out_valid;
  assign busy_m       = sel ? b_busy       : a_busy;
  assign frame_done_m = sel ? b_frame_done : a_frame_done;
  assign out_data_m   = sel ? b_out_data   : a_out_data;

  int cur_w, cur_h, cur_k;
  int img [28][28];
  int wm  [CH][49];
  int bm  [CH];

  typedef struct {
    logic [DW-1:0] data;
    int            hs;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  function automatic logic [DW-1:0] model(input int tr, input int tc);
    logic [DW-1:0] res;
    int acc, v;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc = 0;
      for (int r = 0; r < cur_k; r++)
        for (int c = 0; c < cur_k; c++)
          acc += img[tr+r][tc+c] * wm[ch][r*cur_k+c];
      v = (acc >>> SH) + bm[ch];
      if (v > 2047)  v = 2047;
      if (v < -2048) v = -2048;
`ifdef CONV_RELU_EN
      if (v < 0) v = 0;
`endif
      res[ch*OW +: OW] = v[OW-1:0];
    end
    return res;
  endfunction

  // Output monitor: latency, scoreboard compare, backpressure, frame_done.
  bit            prev_v = 1'b0;
  bit            stall_arm = 1'b0;
  int            res_cnt = 0;
  int            fd_cnt = 0;
  logic [DW-1:0] first_out;

  initial begin
    logic [DW-1:0] hold;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid_m && !prev_v) begin
          if (q.size() > 0) check("latency", 64'(cyc - q[0].hs), 64'(cur_k + 1));
          else              check("out_without_expect", 64'(out_valid_m), 64'(0));
        end
        prev_v = out_valid_m;
        if (out_valid_m && stall_arm && res_cnt == 3) begin
          stall_arm = 1'b0;
          out_ready = 1'b0;
          hold = out_data_m;
          repeat (10) begin
            @(negedge clk);
            check("stall_data_stable", 64'(out_data_m), 64'(hold));
            check("stall_in_ready", 64'(in_ready_m), 64'(0));
            check("stall_valid_held", 64'(out_valid_m), 64'(1));
          end
          out_ready = 1'b1;
        end
        if (out_valid_m && out_ready) begin
          if (q.size() == 0) begin
            check("out_without_expect", 64'(out_valid_m), 64'(0));
          end else begin
            e = q.pop_front();
            check("result", 64'(out_data_m), 64'(e.data));
            if (res_cnt == 0) first_out = out_data_m;
            res_cnt++;
          end
        end
        if (frame_done_m) begin
          fd_cnt++;
          check("frame_done_after_last", 64'(q.size()), 64'(0));
        end
      end
    end
  end

  task automatic write_w(input int addr, input int data);
    int kk;
    kk = cur_k * cur_k;
    w_we = 1'b1;
    w_addr = 7'(addr);
    w_data = 8'(data);
    @(posedge clk); #1;
    w_we = 1'b0;
    if (addr < CH*kk)         wm[addr/kk][addr%kk] = data;
    else if (addr < CH*kk+CH) bm[addr-CH*kk] = data;
  endtask

  task automatic load_identity();
    int kk;
    kk = cur_k * cur_k;
    for (int i = 0; i < CH*kk; i++) write_w(i, (i % kk == kk/2) ? 64 : 0);
    write_w(CH*kk + 0, 0);
    write_w(CH*kk + 1, 5);
    write_w(CH*kk + 2, -3);
  endtask

  task automatic load_uniform(input int wv, input int bv);
    int kk;
    kk = cur_k * cur_k;
    for (int i = 0; i < CH*kk; i++) write_w(i, wv);
    for (int ch = 0; ch < CH; ch++) write_w(CH*kk + ch, bv);
  endtask

  // mode 0: pixel=(r*W+c) mod 256, mode 1: all 255. limit>=0 stops after that
  // many pixels. lock_wr issues a write while busy; first_wr writes together
  // with the first pixel.
  task automatic run_frame(input int mode, input int limit, input bit lock_wr,
                           input bit first_wr, input int fw_addr, input int fw_data);
    int n, t, kk;
    kk = cur_k * cur_k;
    n = 0;
    res_cnt = 0;
    fd_cnt = 0;
    for (int r = 0; r < cur_h; r++) begin
      for (int c = 0; c < cur_w; c++) begin
        if (limit >= 0 && n == limit) return;
        img[r][c] = (mode == 0) ? ((r*cur_w + c) % 256) : 255;
        in_data = 8'(img[r][c]);
        in_valid = 1'b1;
        if (first_wr && n == 0) begin
          w_we = 1'b1;
          w_addr = 7'(fw_addr);
          w_data = 8'(fw_data);
          if (fw_addr < CH*kk) wm[fw_addr/kk][fw_addr%kk] = fw_data;
        end
        if (lock_wr && n == 50) begin
          w_we = 1'b1;
          w_addr = 7'd12;
          w_data = 8'd0;
        end
        t = 0;
        @(negedge clk);
        while (!in_ready_m && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready_m) begin
          check("in_ready_timeout", 64'(in_ready_m), 64'(1));
          finish_now();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_we = 1'b0;
        if (n == 10) check("busy_mid_frame", 64'(busy_m), 64'(1));
        if (r >= cur_k-1 && c >= cur_k-1)
          q.push_back('{data: model(r-cur_k+1, c-cur_k+1), hs: cyc});
        n++;
      end
    end
    t = 0;
    while (fd_cnt == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("result_count", 64'(res_cnt), 64'((cur_w-cur_k+1)*(cur_h-cur_k+1)));
    check("frame_done_pulses", 64'(fd_cnt), 64'(1));
    check("busy_after_frame", 64'(busy_m), 64'(0));
    check("queue_drained", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    check("watchdog_expired", 64'(n_checks), 64'(-1));
    finish_now();
  end

  initial begin
    logic [DW-1:0] exp_first;
    sel = 1'b0;
    cur_w = 28; cur_h = 28; cur_k = 5;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready_m), 64'(0));
    check("rst_out_valid", 64'(out_valid_m), 64'(0));
    check("rst_out_data", 64'(out_data_m), 64'(0));
    check("rst_busy", 64'(busy_m), 64'(0));
    check("rst_frame_done", 64'(frame_done_m), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity kernel; first window centre is pixel 58 -> 14 + bias.
    load_identity();
    run_frame(0, -1, 1'b0, 1'b0, 0, 0);
    exp_first = {12'd11, 12'd19, 12'd14};
    check("identity_first", 64'(first_out), 64'(exp_first));

    // Backpressure at result 3 plus a weight write while busy (must be ignored).
    stall_arm = 1'b1;
    run_frame(0, -1, 1'b1, 1'b0, 0, 0);

    // The same write in IDLE takes effect; out-of-range address is ignored;
    // a write together with the first pixel lands before the first compute.
    write_w(12, 0);
    write_w(100, 85);
    run_frame(0, -1, 1'b0, 1'b1, 37, 32);

    // Positive and negative saturation.
    load_uniform(127, 0);
    run_frame(1, -1, 1'b0, 1'b0, 0, 0);
    check("pos_sat_value", 64'(first_out), 64'({12'd2047, 12'd2047, 12'd2047}));
    load_uniform(-128, 0);
    run_frame(1, -1, 1'b0, 1'b0, 0, 0);

    // Reset after 100 pixels, then a fresh frame with retained weights.
    load_identity();
    run_frame(0, 100, 1'b0, 1'b0, 0, 0);
    check("busy_before_abort", 64'(busy_m), 64'(1));
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready_m), 64'(0));
    check("abort_busy", 64'(busy_m), 64'(0));
    check("abort_out_data", 64'(out_data_m), 64'(0));
    check("abort_out_valid", 64'(out_valid_m), 64'(0));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, -1, 1'b0, 1'b0, 0, 0);
    check("post_reset_first", 64'(first_out), 64'({12'd11, 12'd19, 12'd14}));

    // Small instance: K=3 on 8x6 gives 24 results.
    sel = 1'b1;
    cur_w = 8; cur_h = 6; cur_k = 3;
    @(posedge clk); #1;
    load_identity();
    run_frame(0, -1, 1'b0, 1'b0, 0, 0);

    finish_now();
  end

endmodule

// File: doc/conv_layer_stream.md
Name: conv_layer_stream

Overview:
- Parametrised streaming 2-D convolution layer; next generation of the first-layer convolution engine.
- Accepts one raster-order pixel per handshake and keeps KSIZE rows in a circular line buffer.
- Computes CH_OUT valid-mode convolutions per window, one kernel row per cycle, using KSIZE MACs per channel.
- Weights and biases are loaded at run time through a write port, and the output has valid/ready backpressure.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- KSIZE, 5, square kernel size (3..7)
- CH_OUT, 3, output channel count
- DATA_W, 8, unsigned pixel width
- WGT_W, 8, signed weight/bias width
- OUT_W, 12, signed output width per channel
- SHIFT, 8, arithmetic right shift applied to accumulator before bias add

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_data  in  DATA_W  pixel, raster order
- in_valid  in  1  pixel valid
- in_ready  out  1  block can accept pixel
- w_we  in  1  weight/bias write strobe
- w_addr  in  clog2(CH_OUT*KSIZE*KSIZE+CH_OUT)  weight index ch*K*K+r*K+c; bias at CH_OUT*K*K+ch
- w_data  in  WGT_W  signed weight/bias value
- out_data  out  CH_OUT*OUT_W  channel ch in bits [ch*OUT_W +: OUT_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last result of a frame is accepted

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - Outputs: in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0.
  - Counters and state are cleared.
  - Weight/bias storage is NOT reset; contents are retained.
- State machine:
  - IDLE: in_ready=1. On the first accepted pixel, go to STREAM and set busy=1.
  - STREAM: in_ready=1; accept pixel at (row, col) into line buffer slot row mod KSIZE.
    - If row>=KSIZE-1 and col>=KSIZE-1 after the write, go to COMPUTE with window top-left (row-KSIZE+1, col-KSIZE+1).
    - Otherwise stay in STREAM.
  - COMPUTE: in_ready=0. Runs KSIZE cycles; cycle r adds the products of window row r for all channels.
    - First cycle clears the accumulators.
    - Window pixels are read from the line buffer at circular row index (top+r) mod KSIZE.
    - Then go to OUTPUT.
  - OUTPUT: out_valid=1, out_data held stable until out_ready. On the handshake:
    - Last window of the frame: pulse frame_done, clear busy, go to IDLE.
    - Otherwise go to STREAM.
- Latency: out_valid rises exactly KSIZE+1 cycles after the handshake of the window-completing pixel.
- Results per frame: (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1), which is 576 at defaults.
- Arithmetic:
  - Product = {1'b0, pixel} (signed) * weight.
  - Accumulator width = DATA_W+WGT_W+clog2(KSIZE*KSIZE)+1, so it cannot overflow.
  - result = (acc >>> SHIFT) + sign-extended bias, then saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pixel counters: col wraps IMG_W-1→0 and increments row; after row IMG_H-1, col IMG_W-1 the counters return to 0.
- Line buffer writes happen only on an in_valid&&in_ready handshake. in_valid while in_ready=0 is ignored; the source must hold the pixel.
- Weight port:
  - w_we is honoured only in IDLE; ignored otherwise, including when busy.
  - Addresses beyond the bias range are ignored.
  - A write to an address on the same cycle as a frame start completes before the first compute.
- Simultaneous w_we and first in_valid in IDLE: both take effect.
- rst mid-frame: all counters, partial windows and pending results are discarded; the next pixel after reset is treated as (0,0).
- out_ready held high in OUTPUT: one-cycle output phase, no bubble beyond the fixed KSIZE compute cycles.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: after saturation, negative channel results are replaced by 0 (ReLU fused); valid timing unchanged.
- Undefined: signed saturated results are emitted unmodified.

Test Plan:
- Identity kernel, defaults:
  - Stimulus: all weights 0 except centre (index 12) = 64 in every channel; biases 0,5,-3; pixel(r,c)=(r*28+c) mod 256.
  - Response: first result ch0=14, ch1=19, ch2=11; 576 results, then one frame_done pulse.
- Positive saturation: all weights 127, bias 0, all pixels 255 → acc=809625, >>8 = 3162 → every channel outputs 2047.
- Negative saturation: all weights -128, all pixels 255 → each channel -2048 without CONV_RELU_EN, 0 with it.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles at result 3.
  - Response: out_data stable, in_ready=0, no pixel lost; result sequence identical to the out_ready=1 run; latency KSIZE+1=6 cycles from the completing pixel.
- Weight-write lockout: w_we issued while busy leaves outputs unchanged; the same write in IDLE changes the next frame's results.
- Reset mid-frame and param sweep:
  - Assert rst after 100 pixels → outputs return to reset values immediately; a fresh frame then produces a correct 576-result run.
  - Repeat identity test with KSIZE=3, IMG_W=8, IMG_H=6 → 24 results.
